// File: rtl/bidir_chan_scanner.sv
// bidir_chan_scanner
//   Scans the 8-channel 1-bit readback mux of the BiDirChannels IP. It drives
//   sel, waits for the pad/analogue path and the synchroniser to settle, and
//   samples the synchronised bit. One bit per enabled channel is collected
//   into an 8-bit snapshot, which is handed to the consumer over valid/ready.
//   Scans can be single-shot (start) or continuous.
// Ports:
//   clk, rst_n        block clock, asynchronous active-low reset
//   start             one-scan request, honoured only when idle
//   continuous        start the next scan on the accept edge / from idle
//   ch_mask[7:0]      channel enables, latched at scan start
//   mux_in            muxed channel bit, asynchronous to clk
//   sel[2:0]          mux select
//   snap_data[7:0]    snapshot; disabled channels read 0
//   snap_valid/ready  snapshot handshake
//   busy              any state other than IDLE
//   scan_cnt[7:0]     accepted-scan counter, wraps
module bidir_chan_scanner #(
   parameter int SETTLE_CYCLES = 2,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       continuous,
   input  logic [7:0] ch_mask,
   input  logic       mux_in,
   output logic [2:0] sel,
   output logic [7:0] snap_data,
   output logic       snap_valid,
   input  logic       snap_ready,
   output logic       busy,
   output logic [7:0] scan_cnt
);

   // Cycles per enabled channel: T-1 in SETTLE plus one in SAMPLE.
   localparam int T  = SETTLE_CYCLES + SYNC_STAGES + 1;
   localparam int CW = $clog2(T);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, OUTPUT} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [7:0]             mask_q, mask_d;
   logic [7:0]             shadow_q, shadow_d;
   logic [7:0]             snap_q, snap_d;
   logic [2:0]             sel_q, sel_d;
   logic                   valid_q, valid_d;
   logic [7:0]             scan_q, scan_d;

   logic                   sync_bit;
   logic [7:0]             shadow_fin;
   logic [2:0]             nxt_sel;
   logic                   has_nxt;
   logic                   req_ok;

   function automatic logic [2:0] lowest_ch(input logic [7:0] m);
      lowest_ch = '0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) lowest_ch = 3'(i);
   endfunction

   assign sync_bit = sync_q[SYNC_STAGES-1];
   assign req_ok   = (ch_mask != 8'h00);

   // Next enabled channel above the current one, from the latched mask.
   always_comb begin
      nxt_sel = '0;
      has_nxt = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (mask_q[i] && (3'(i) > sel_q)) begin
            nxt_sel = 3'(i);
            has_nxt = 1'b1;
         end
      end
   end

   always_comb begin
      shadow_fin         = shadow_q;
      shadow_fin[sel_q]  = sync_bit;
   end

   always_comb begin
      state_d  = state_q;
      sync_d   = {sync_q[SYNC_STAGES-2:0], mux_in};
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      snap_d   = snap_q;
      sel_d    = sel_q;
      valid_d  = valid_q;
      scan_d   = scan_q;
      case (state_q)
         IDLE: begin
            sel_d = '0;
            if ((start || continuous) && req_ok) begin
               mask_d   = ch_mask;
               shadow_d = '0;
               sel_d    = lowest_ch(ch_mask);
               cnt_d    = '0;
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == CW'(T - 2)) state_d = SAMPLE;
            else                     cnt_d   = cnt_q + CW'(1);
         end
         SAMPLE: begin
            shadow_d = shadow_fin;
            if (has_nxt) begin
               sel_d   = nxt_sel;
               cnt_d   = '0;
               state_d = SETTLE;
            end else begin
               snap_d  = shadow_fin;
               valid_d = 1'b1;
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            if (snap_ready) begin
               valid_d = 1'b0;
               scan_d  = scan_q + 8'd1;
               // Back-to-back restart on the accept edge: no IDLE cycle.
               if (continuous && req_ok) begin
                  mask_d   = ch_mask;
                  shadow_d = '0;
                  sel_d    = lowest_ch(ch_mask);
                  cnt_d    = '0;
                  state_d  = SETTLE;
               end else begin
                  sel_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sync_q   <= '0;
         cnt_q    <= '0;
         mask_q   <= '0;
         shadow_q <= '0;
         snap_q   <= '0;
         sel_q    <= '0;
         valid_q  <= 1'b0;
         scan_q   <= '0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         snap_q   <= snap_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         scan_q   <= scan_d;
      end
   end

   assign sel        = sel_q;
   assign snap_data  = snap_q;
   assign snap_valid = valid_q;
   assign busy       = (state_q != IDLE);
   assign scan_cnt   = scan_q;

endmodule

// File: tb/tb_bidir_chan_scanner.sv
// Directed bench for bidir_chan_scanner with a behavioural 8:1 mux model.
module tb_bidir_chan_scanner;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       continuous;
   logic [7:0] ch_mask;
   logic       mux_in;
   logic [2:0] sel;
   logic [7:0] snap_data;
   logic       snap_valid;
   logic       snap_ready;
   logic       busy;
   logic [7:0] scan_cnt;
   logic [7:0] pattern;

   int total = 0;
   int bad   = 0;

   bidir_chan_scanner dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .continuous (continuous),
      .ch_mask    (ch_mask),
      .mux_in     (mux_in),
      .sel        (sel),
      .snap_data  (snap_data),
      .snap_valid (snap_valid),
      .snap_ready (snap_ready),
      .busy       (busy),
      .scan_cnt   (scan_cnt)
   );

   assign mux_in = pattern[sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs the remaining cycles of a scan; valid must rise exactly at the end.
   task automatic scan_wait(input int cycles, input logic [7:0] exp_data, input string tag);
      logic early;
      logic idle;
      early = 1'b0;
      idle  = 1'b0;
      for (int k = 1; k < cycles; k++) begin
         tick();
         if (snap_valid) early = 1'b1;
         if (!busy)      idle  = 1'b1;
      end
      tick();
      chk({tag, "_early_valid"}, 32'(early), 32'd0);
      chk({tag, "_busy"},        32'(idle),  32'd0);
      chk({tag, "_valid"},       32'(snap_valid), 32'd1);
      chk({tag, "_data"},        32'(snap_data),  32'(exp_data));
   endtask

   initial begin
      logic flag;
      int   n;
      rst_n = 1'b0; start = 1'b0; continuous = 1'b0; ch_mask = 8'h00;
      snap_ready = 1'b0; pattern = 8'h00;
      #12;
      chk("rst_sel",   32'(sel),        32'd0);
      chk("rst_data",  32'(snap_data),  32'd0);
      chk("rst_valid", 32'(snap_valid), 32'd0);
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_cnt",   32'(scan_cnt),   32'd0);
      rst_n = 1'b1;
      tick();

      // Full scan, 0xA5: sel steps every 5 cycles, valid at edge 40.
      ch_mask = 8'hFF; pattern = 8'hA5; start = 1'b1;
      tick();
      start = 1'b0;
      flag = 1'b0;
      for (int k = 1; k < 40; k++) begin
         tick();
         if (sel != 3'(k / 5) || snap_valid || !busy) flag = 1'b1;
      end
      chk("full_seq", 32'(flag), 32'd0);
      tick();
      chk("full_valid", 32'(snap_valid), 32'd1);
      chk("full_data",  32'(snap_data),  32'hA5);
      chk("full_sel",   32'(sel),        32'd7);
      chk("full_busy",  32'(busy),       32'd1);
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      chk("full_acc_valid", 32'(snap_valid), 32'd0);
      chk("full_acc_cnt",   32'(scan_cnt),   32'd1);
      chk("full_acc_busy",  32'(busy),       32'd0);

      // Sparse mask 0x81 then backpressure.
      ch_mask = 8'h81; pattern = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0;
      flag = 1'b0;
      for (int k = 1; k < 10; k++) begin
         tick();
         if (sel != ((k < 5) ? 3'd0 : 3'd7) || snap_valid) flag = 1'b1;
      end
      chk("sparse_seq", 32'(flag), 32'd0);
      tick();
      chk("sparse_valid", 32'(snap_valid), 32'd1);
      chk("sparse_data",  32'(snap_data),  32'h81);
      flag = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (!snap_valid || snap_data != 8'h81 || sel != 3'd7) flag = 1'b1;
      end
      chk("bp_stable", 32'(flag), 32'd0);
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      chk("bp_acc_valid", 32'(snap_valid), 32'd0);
      chk("bp_acc_cnt",   32'(scan_cnt),   32'd2);
      chk("bp_acc_busy",  32'(busy),       32'd0);

      // Continuous, three back-to-back scans.
      ch_mask = 8'hFF; pattern = 8'h0F; continuous = 1'b1; snap_ready = 1'b1;
      tick();
      scan_wait(40, 8'h0F, "cont1");
      pattern = 8'hF0;
      tick();
      chk("cont1_acc_valid", 32'(snap_valid), 32'd0);
      chk("cont1_acc_busy",  32'(busy),       32'd1);
      scan_wait(40, 8'hF0, "cont2");
      pattern = 8'h3C;
      tick();
      chk("cont2_acc_busy", 32'(busy), 32'd1);
      continuous = 1'b0;
      scan_wait(40, 8'h3C, "cont3");
      tick();
      chk("cont3_acc_valid", 32'(snap_valid), 32'd0);
      chk("cont3_acc_busy",  32'(busy),       32'd0);
      chk("cont_cnt",        32'(scan_cnt),   32'd5);
      snap_ready = 1'b0;

      // A start pulse mid-scan is ignored: exactly one snapshot.
      pattern = 8'h55; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      scan_wait(30, 8'h55, "ign");
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      chk("ign_acc_cnt", 32'(scan_cnt), 32'd6);
      flag = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (busy || snap_valid) flag = 1'b1;
      end
      chk("ign_no_second", 32'(flag), 32'd0);

      // Empty mask: request dropped.
      ch_mask = 8'h00; start = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      start = 1'b0;
      chk("mask0_busy", 32'(busy), 32'd0);
      chk("mask0_sel",  32'(sel),  32'd0);

      // Asynchronous reset while sel=3.
      ch_mask = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 15; k++) tick();
      chk("mid_sel", 32'(sel), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_sel",   32'(sel),        32'd0);
      chk("arst_data",  32'(snap_data),  32'd0);
      chk("arst_valid", 32'(snap_valid), 32'd0);
      chk("arst_busy",  32'(busy),       32'd0);
      chk("arst_cnt",   32'(scan_cnt),   32'd0);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_sel",  32'(sel),  32'd0);

      // Counter wrap after 256 accepted scans.
      ch_mask = 8'h01; pattern = 8'hFF; continuous = 1'b1; snap_ready = 1'b1;
      n = 0;
      while (scan_cnt != 8'd255 && n < 3000) begin
         tick();
         n++;
      end
      chk("wrap_255", 32'(scan_cnt), 32'd255);
      continuous = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      chk("wrap_idle", 32'(busy),      32'd0);
      chk("wrap_cnt",  32'(scan_cnt),  32'd0);
      chk("wrap_data", 32'(snap_data), 32'h01);
      snap_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
